// File: rtl/smul_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
package smul_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int SMUL_W_DEFAULT = 16;

   // Step counter only has to reach W-1.
   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/smul_if.sv
// Operand/result handshake bundle for smul_seq; ovf exists only with SMUL_OVF_EN.
interface smul_if #(
   parameter int W = 16
);
   logic             go;
   logic [W-1:0]     multiplicand;
   logic [W-1:0]     multiplier;
   logic             rdy;
   logic [2*W-1:0]   product;
`ifdef SMUL_OVF_EN
   logic             ovf;
`endif

   modport master (
      output go, multiplicand, multiplier,
`ifdef SMUL_OVF_EN
      input  ovf,
`endif
      input  rdy, product
   );

   modport slave (
      input  go, multiplicand, multiplier,
`ifdef SMUL_OVF_EN
      output ovf,
`endif
      output rdy, product
   );
endinterface

// File: rtl/smul_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then arithmetic
// shift right of {A,Q,q_-1}.
module smul_booth_step #(
   parameter int W = 16
) (
   input  logic signed [W:0]   a_i,
   input  logic        [W-1:0] q_i,
   input  logic                qm1_i,
   input  logic signed [W:0]   m_i,
   output logic signed [W:0]   a_o,
   output logic        [W-1:0] q_o,
   output logic                qm1_o
);

   logic signed [W:0] sum;

   always_comb begin
      case ({q_i[0], qm1_i})
         2'b01:   sum = a_i + m_i;
         2'b10:   sum = a_i - m_i;
         default: sum = a_i;
      endcase
      a_o   = {sum[W], sum[W:1]};
      q_o   = {sum[0], q_i[W-1:1]};
      qm1_o = q_i[0];
   end

endmodule

// File: rtl/smul_seq.sv
// Sequential signed multiplier, W Booth steps per product, go/rdy handshake.
// Optional SMUL_OVF_EN adds an ovf flag for products not fitting in W bits.
module smul_seq
   import smul_pkg::*;
#(
   parameter int W = SMUL_W_DEFAULT
) (
   input  logic   clk,
   input  logic   rst,
   smul_if.slave  bus
);

   localparam int CW = cnt_width(W);

   state_t                 state_q, state_d;
   logic        [CW-1:0]   cnt_q, cnt_d;
   logic signed [W:0]      a_q, a_d;
   logic        [W-1:0]    q_q, q_d;
   logic                   qm1_q, qm1_d;
   logic signed [W:0]      m_q, m_d;
   logic                   rdy_q, rdy_d;
   logic        [2*W-1:0]  product_q, product_d;
   logic                   ovf_q, ovf_d;

   logic signed [W:0]      a_nx;
   logic        [W-1:0]    q_nx;
   logic                   qm1_nx;
   logic        [2*W-1:0]  prod_nx;

   smul_booth_step #(.W(W)) u_step (
      .a_i   (a_q),
      .q_i   (q_q),
      .qm1_i (qm1_q),
      .m_i   (m_q),
      .a_o   (a_nx),
      .q_o   (q_nx),
      .qm1_o (qm1_nx)
   );

   assign prod_nx = {a_nx[W-1:0], q_nx};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      q_d       = q_q;
      qm1_d     = qm1_q;
      m_d       = m_q;
      rdy_d     = rdy_q;
      product_d = product_q;
      ovf_d     = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.go) begin
               m_d     = {bus.multiplicand[W-1], bus.multiplicand};
               q_d     = bus.multiplier;
               a_d     = '0;
               qm1_d   = 1'b0;
               cnt_d   = '0;
               rdy_d   = 1'b0;
               ovf_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = a_nx;
            q_d   = q_nx;
            qm1_d = qm1_nx;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               product_d = prod_nx;
               rdy_d     = 1'b1;
               // Fits in W signed bits only when the top W+1 bits are a pure sign run.
               ovf_d     = ~((&prod_nx[2*W-1:W-1]) | ~(|prod_nx[2*W-1:W-1]));
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         q_q       <= '0;
         qm1_q     <= 1'b0;
         m_q       <= '0;
         rdy_q     <= 1'b0;
         product_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         q_q       <= q_d;
         qm1_q     <= qm1_d;
         m_q       <= m_d;
         rdy_q     <= rdy_d;
         product_q <= product_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.rdy     = rdy_q;
   assign bus.product = product_q;
`ifdef SMUL_OVF_EN
   assign bus.ovf     = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_smul_seq.sv
// Scoreboard bench for smul_seq (W=16); ovf checks are active with SMUL_OVF_EN.
module tb_smul_seq;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   smul_if #(.W(W)) bus ();

   smul_seq #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [2*W-1:0] exp_q[$];
   logic           exp_ovf_q[$];

   // Drive one go pulse; push the reference result. Called #1 after an edge.
   task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q);
      longint p;
      bus.go           = 1'b1;
      bus.multiplicand = m;
      bus.multiplier   = q;
      p = longint'($signed(m)) * longint'($signed(q));
      exp_q.push_back(p[2*W-1:0]);
      exp_ovf_q.push_back((p > 32767) || (p < -32768));
      @(posedge clk);
      #1;
      bus.go = 1'b0;
   endtask

   // Edges after the accept edge until rdy is seen; -1 if it never comes.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.rdy) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.go           = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.rdy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_rdy got=%b want=0", bus.rdy);
      end
      n_cmp++;
      if (bus.product !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_product got=%h want=00000000", bus.product);
      end
`ifdef SMUL_OVF_EN
      n_cmp++;
      if (bus.ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ovf got=%b want=0", bus.ovf);
      end
`endif
   endtask

   task automatic run_and_check(input string name, input logic [W-1:0] m,
                                input logic [W-1:0] q);
      int lat;
      logic [2*W-1:0] e;
      logic           eo;
      start_op(m, q);
      n_cmp++;
      if (bus.rdy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_rdy_fall got=%b want=0", name, bus.rdy);
      end
      wait_done(lat);
      e  = exp_q.pop_front();
      eo = exp_ovf_q.pop_front();
      n_cmp++;
      if (lat !== 16) begin
         n_bad++;
         $display("FAIL %s_latency got=%0d want=16", name, lat);
      end
      n_cmp++;
      if (bus.product !== e) begin
         n_bad++;
         $display("FAIL %s_product got=%h want=%h", name, bus.product, e);
      end
`ifdef SMUL_OVF_EN
      n_cmp++;
      if (bus.ovf !== eo) begin
         n_bad++;
         $display("FAIL %s_ovf got=%b want=%b", name, bus.ovf, eo);
      end
`else
      if (eo === 1'bx) $display("note: unknown ovf reference");
`endif
   endtask

   task automatic test_basic();
      run_and_check("basic_3x5", 16'd3, 16'd5);
      n_cmp++;
      if (bus.product !== 32'h0000000F) begin
         n_bad++;
         $display("FAIL basic_const got=%h want=0000000f", bus.product);
      end
   endtask

   task automatic test_signs();
      logic [2*W-1:0] held;
      run_and_check("neg8x2", 16'hFFF8, 16'd2);
      n_cmp++;
      if (bus.product !== 32'hFFFFFFF0) begin
         n_bad++;
         $display("FAIL neg8x2_const got=%h want=fffffff0", bus.product);
      end
      run_and_check("min_x_min", 16'h8000, 16'h8000);
      n_cmp++;
      if (bus.product !== 32'h40000000) begin
         n_bad++;
         $display("FAIL min_x_min_const got=%h want=40000000", bus.product);
      end
      held = bus.product;
      repeat (5) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.rdy !== 1'b1 || bus.product !== held) begin
         n_bad++;
         $display("FAIL idle_hold got=%b/%h want=1/%h", bus.rdy, bus.product, held);
      end
      run_and_check("zero_op", 16'h0000, 16'h8123);
   endtask

   task automatic test_go_ignored();
      int lat;
      logic [2*W-1:0] e;
      logic           eo;
      start_op(16'h7FFF, 16'h8000);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         if (i == 5) begin
            bus.go           = 1'b1;
            bus.multiplicand = 16'h1234;
            bus.multiplier   = 16'h0077;
         end else begin
            bus.go = 1'b0;
         end
         @(posedge clk);
         #1;
         if (bus.rdy) begin
            lat = i;
            break;
         end
      end
      bus.go = 1'b0;
      e  = exp_q.pop_front();
      eo = exp_ovf_q.pop_front();
      n_cmp++;
      if (lat !== 16) begin
         n_bad++;
         $display("FAIL go_in_run_latency got=%0d want=16", lat);
      end
      n_cmp++;
      if (bus.product !== e || e !== 32'hC0008000) begin
         n_bad++;
         $display("FAIL go_in_run_product got=%h want=c0008000", bus.product);
      end
`ifdef SMUL_OVF_EN
      n_cmp++;
      if (bus.ovf !== eo) begin
         n_bad++;
         $display("FAIL go_in_run_ovf got=%b want=%b", bus.ovf, eo);
      end
`endif
      // Result must still be held afterwards: the stray go was not accepted.
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL go_in_run_no_restart got=%b want=1", bus.rdy);
      end
   endtask

   task automatic test_reset_mid_run();
      start_op(16'd100, 16'hFFFD);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      void'(exp_q.pop_front());
      void'(exp_ovf_q.pop_front());
      n_cmp++;
      if (bus.rdy !== 1'b0 || bus.product !== 32'h0) begin
         n_bad++;
         $display("FAIL midrun_reset got=%b/%h want=0/00000000", bus.rdy, bus.product);
      end
      repeat (20) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.rdy !== 1'b0 || bus.product !== 32'h0) begin
         n_bad++;
         $display("FAIL midrun_aborted got=%b/%h want=0/00000000", bus.rdy, bus.product);
      end
      run_and_check("after_reset", 16'd100, 16'hFFFD);
      n_cmp++;
      if (bus.product !== 32'hFFFFFED4) begin
         n_bad++;
         $display("FAIL after_reset_const got=%h want=fffffed4", bus.product);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ms [8];
      logic [W-1:0] qs [8];
      ms[0] = 16'h7FFF; qs[0] = 16'h7FFF;
      ms[1] = 16'h8000; qs[1] = 16'h7FFF;
      ms[2] = 16'hFFFF; qs[2] = 16'hFFFF;
      ms[3] = 16'h0001; qs[3] = 16'h8000;
      for (int i = 4; i < 8; i++) begin
         ms[i] = 16'($urandom);
         qs[i] = 16'($urandom);
      end
      // Each run_and_check starts right in the first IDLE cycle after rdy.
      for (int i = 0; i < 8; i++) begin
         run_and_check($sformatf("b2b%0d", i), ms[i], qs[i]);
      end
   endtask

   initial begin
      bus.go           = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      test_reset();
      test_basic();
      test_signs();
      test_go_ignored();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/smul_seq.md
Name: smul_seq

Overview:
- Sequential signed multiplier; the arithmetic inverse of the team's sequential signed divider, with the same go/rdy operand handshake.
- Computes a 2W-bit two's-complement product of two W-bit signed operands using radix-2 Booth recoding, one iteration per clock.
- Sits beside the divider in the datapath for fixed-point scale and unscale operations.

Parameters:
- W, 16, operand width in bits. Product width is 2*W. Legal values are W >= 4.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset.
- go  input  1  start request; operands are sampled on the rising edge where go=1 in IDLE.
- multiplicand  input  W  signed operand M.
- multiplier  input  W  signed operand Q.
- rdy  output  1  high when product holds a valid result of the last accepted operation.
- product  output  2W  signed result, registered.
- Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, rdy=0, product=0, iteration count=0, internal A/Q/q_-1/M cleared.
  - rst has priority over go and over any in-flight iteration.
- State IDLE:
  - On go=1: M <= multiplicand (sign-extended to W+1 bits), Q <= multiplier, A <= 0, q_-1 <= 0, cnt <= 0, rdy <= 0, state <= RUN.
  - product holds its previous value.
- State RUN, one Booth step per cycle:
  - {Q[0],q_-1}=01: A += M.
  - {Q[0],q_-1}=10: A -= M.
  - 00 or 11: no change to A.
  - Then arithmetic shift right of {A,Q,q_-1} by 1; A is W+1 bits wide so that M = -2^(W-1) cannot overflow.
  - cnt increments each step.
  - On the step where cnt = W-1: product <= {A[W-1:0],Q} after the shift, rdy <= 1, state <= IDLE.
- Latency:
  - Go sampled at edge 0; steps run at edges 1..W.
  - rdy and product are valid after edge W (edge 16 for W=16).
  - Back-to-back: go may be reasserted in the first IDLE cycle after completion.
- go while in RUN is ignored; operand changes during RUN are ignored.
- rdy stays high and product stays stable until the next accepted go. rdy falls on the edge that accepts go.
- Corner cases: -2^(W-1) * -2^(W-1) = +2^(2W-2) is exact, with no overflow. A zero operand still takes W steps.
- Reset mid-RUN aborts the operation. rdy=0 and product=0 until the next completion.

Optional Feature:
- Macro SMUL_OVF_EN.
- Defined:
  - Adds output ovf (1 bit), registered together with product.
  - ovf=1 when the product is not representable as W-bit signed, i.e. product[2W-1:W-1] is not all-equal.
  - ovf resets to 0, holds with product, and clears on accepted go.
- Undefined: no ovf port and no related logic.

Decomposition:
- Package smul_pkg holds:
  - enum state_t {IDLE, RUN}.
  - Localparam default width 16.
  - Function clog2-based count width for cnt.
- One sub-module is natural: smul_booth_step. It is purely combinational: it takes A, Q, q_-1 and M, and returns the next A, Q and q_-1 after add/sub and the arithmetic shift.
- The FSM, counter and output registers stay in smul_seq.

Test Plan:
- 1. rst=1 for 2 cycles, then release -> rdy=0, product=0x00000000.
- 2. go=1 one cycle, M=3, Q=5 -> rdy rises exactly 16 edges after the go edge, product=0x0000000F (ovf=0).
- 3. M=-8 (0xFFF8), Q=2 -> product=0xFFFFFFF0. Then M=0x8000, Q=0x8000 -> product=0x40000000 (ovf=1).
- 4. M=0x7FFF, Q=0x8000 -> product=0xC0008000. Pulse go again at cycle 5 of RUN with other operands -> ignored, result unchanged, latency still 16.
- 5. Start M=100, Q=-3. Assert rst at cycle 8 of RUN -> rdy=0, product=0. A new go with M=100, Q=-3 -> product=0xFFFFFED4.
- 6. Back-to-back: go on the first cycle after rdy rises -> rdy drops on that edge, new result after 16 edges. Random signed pairs are checked against a reference model.
